// File: rtl/fft_seq_ctrl_pkg.sv
// Shared types for the radix-2 FFT stage sequencer: FSM states, log2n width
// and the read/write-back address pair carried through the write shift line.
package fft_pkg;

  localparam int LOG2N_W = 4;
  // Widest address the pair can carry; instances use the low ADDR_W bits
  localparam int PAIR_AW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fft_seq_state_e;

  typedef struct packed {
    logic               valid;
    logic [PAIR_AW-1:0] a1;
    logic [PAIR_AW-1:0] a2;
  } fft_pair_t;

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Control and SRAM-address bundle between the FFT top (master) and the
// stage sequencer (slave).
interface fft_seq_ctrl_if import fft_pkg::*; #(
  parameter int ADDR_W    = 8,
  parameter int MAX_LOG2N = 8
);

  logic                 i_start;
  logic                 i_abort;
  logic [LOG2N_W-1:0]   i_log2n;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [LOG2N_W-1:0]   o_stage;
  logic                 o_rd_valid;
  logic [ADDR_W-1:0]    o_raddress1;
  logic [ADDR_W-1:0]    o_raddress2;
  logic [MAX_LOG2N-2:0] o_twiddle;
  logic                 o_wr_en;
  logic [ADDR_W-1:0]    o_waddress1;
  logic [ADDR_W-1:0]    o_waddress2;

  modport master (
    output i_start, i_abort, i_log2n,
    input  o_busy, o_done, o_err, o_stage, o_rd_valid, o_raddress1,
           o_raddress2, o_twiddle, o_wr_en, o_waddress1, o_waddress2
  );

  modport slave (
    input  i_start, i_abort, i_log2n,
    output o_busy, o_done, o_err, o_stage, o_rd_valid, o_raddress1,
           o_raddress2, o_twiddle, o_wr_en, o_waddress1, o_waddress2
  );

endinterface

// File: rtl/fft_seq_ctrl_wb_delay.sv
// Write-back shift line: delays the issued read pair by DEPTH cycles so it
// lines up with the butterfly result; flush drops everything in flight.
module fft_wb_delay import fft_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_flush,
  input  fft_pair_t i_pair,
  output fft_pair_t o_pair
);

  fft_pair_t r_line [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
    end else begin
      r_line[0] <= i_pair;
      for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
    end
  end

  assign o_pair = r_line[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// In-place DIT radix-2 FFT stage sequencer: one butterfly read pair per cycle,
// drain bubbles between stages, write-back after PIPE_LAT cycles.
//
// state | meaning
// IDLE  | waiting for start; illegal L pulses o_err
// ISSUE | one read pair per cycle, j = 0 .. 2^(L-1)-1
// DRAIN | PIPE_LAT bubble cycles until the stage's last write lands
// DONE  | one-cycle o_done, then back to IDLE
module fft_seq_ctrl import fft_pkg::*; #(
  parameter int ADDR_W    = 8,
  parameter int MAX_LOG2N = 8,
  parameter int PIPE_LAT  = 4
) (
  input  logic          clk,
  input  logic          rstn,
  fft_seq_ctrl_if.slave bus
);

  localparam int JW    = MAX_LOG2N - 1;
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [JW-1:0]      J_ONE    = JW'(1);
  localparam logic [LOG2N_W-1:0] L_ONE    = LOG2N_W'(1);
  localparam logic [LOG2N_W-1:0] MAX_L    = LOG2N_W'(MAX_LOG2N);
  localparam logic [ADDR_W-1:0]  A_ONE    = ADDR_W'(1);

  fft_seq_state_e     r_state, w_state_nxt;
  logic [LOG2N_W-1:0] r_l, w_l_nxt, r_s, w_s_nxt;
  logic [JW-1:0]      r_j, w_j_nxt, w_j_last, r_tw, w_tw;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_busy, w_busy_nxt, r_done, w_done_nxt, r_err, w_err_nxt;
  logic               r_rd_valid, w_valid_nxt, w_flush, w_start_ok;
  logic [ADDR_W-1:0]  r_a1, r_a2, w_half, w_k, w_a1, w_j_ext;
  fft_pair_t          w_rd_pair, w_wb_pair;

  assign w_start_ok = (bus.i_log2n != '0) && (bus.i_log2n <= MAX_L);
  assign w_j_last   = JW'((32'd1 << (r_l - L_ONE)) - 32'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_l_nxt     = r_l;
    w_s_nxt     = r_s;
    w_j_nxt     = r_j;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          if (w_start_ok) begin
            w_state_nxt = ISSUE;
            w_l_nxt     = bus.i_log2n;
            w_s_nxt     = '0;
            w_j_nxt     = '0;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (r_j == w_j_last) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_j_nxt     = r_j + J_ONE;
          w_valid_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          if (r_s < r_l - L_ONE) begin
            w_state_nxt = ISSUE;
            w_s_nxt     = r_s + L_ONE;
            w_j_nxt     = '0;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a start seen in IDLE
    if (bus.i_abort) begin
      w_state_nxt = IDLE;
      w_l_nxt     = r_l;
      w_s_nxt     = r_s;
      w_j_nxt     = r_j;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_flush     = 1'b1;
    end
  end

  // Addresses for the pair that becomes visible next cycle
  assign w_half  = A_ONE << w_s_nxt;
  assign w_j_ext = ADDR_W'(w_j_nxt);
  assign w_k     = w_j_ext & (w_half - A_ONE);
  assign w_a1    = ((w_j_ext >> w_s_nxt) << (w_s_nxt + L_ONE)) | w_k;
  assign w_tw    = JW'(w_k << (w_l_nxt - L_ONE - w_s_nxt));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_l        <= '0;
      r_s        <= '0;
      r_j        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_tw       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_l        <= w_l_nxt;
      r_s        <= w_s_nxt;
      r_j        <= w_j_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_rd_valid <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_a1 <= w_a1;
        r_a2 <= w_a1 | w_half;
        r_tw <= w_tw;
      end
    end
  end

  assign w_rd_pair.valid = r_rd_valid;
  assign w_rd_pair.a1    = PAIR_AW'(r_a1);
  assign w_rd_pair.a2    = PAIR_AW'(r_a2);

  fft_wb_delay #(.DEPTH(PIPE_LAT)) u_wb_delay (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (w_flush),
    .i_pair  (w_rd_pair),
    .o_pair  (w_wb_pair)
  );

  generate
    if (ADDR_W < PAIR_AW) begin : g_pair_hi
      logic w_unused_hi;
      assign w_unused_hi = ^{w_wb_pair.a1[PAIR_AW-1:ADDR_W], w_wb_pair.a2[PAIR_AW-1:ADDR_W]};
    end
  endgenerate

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_err       = r_err;
  assign bus.o_stage     = r_s;
  assign bus.o_rd_valid  = r_rd_valid;
  assign bus.o_raddress1 = r_a1;
  assign bus.o_raddress2 = r_a2;
  assign bus.o_twiddle   = r_tw;
  assign bus.o_wr_en     = w_wb_pair.valid;
  assign bus.o_waddress1 = w_wb_pair.a1[ADDR_W-1:0];
  assign bus.o_waddress2 = w_wb_pair.a2[ADDR_W-1:0];

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: a block/offset reference model queues the
// expected read, write, done and err events; a negedge monitor matches them.
module tb_fft_seq_ctrl;

  localparam int AW = 8;
  localparam int ML = 8;
  localparam int P  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_seq_ctrl_if #(.ADDR_W(AW), .MAX_LOG2N(ML)) bus ();

  fft_seq_ctrl #(.ADDR_W(AW), .MAX_LOG2N(ML), .PIPE_LAT(P)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int cyc;
    int a1;
    int a2;
    int tw;
    int st;
  } ev_t;

  ev_t rdq[$];
  ev_t wrq[$];
  int  doneq[$];
  int  errq[$];

  int  cyc = 0;
  int  nchk = 0;
  int  npass = 0;
  int  busy_from = 1;
  int  busy_to = 0;
  int  hold_a1 = 0, hold_a2 = 0, hold_tw = 0;
  bit  mon_en = 1'b0;
  ev_t m_ev;
  bit  m_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Reference: stage s splits 2^L words into blocks of 2^(s+1); each block
  // pairs offset k with k + 2^s and uses twiddle k * 2^(L-1-s).
  task automatic push_run(input int l, input int t0);
    int  pairs = 1 << (l - 1);
    ev_t e;
    for (int s = 0; s < l; s++) begin
      int h   = 1 << s;
      int idx = 0;
      for (int base = 0; base < (1 << l); base += 2 * h) begin
        for (int k = 0; k < h; k++) begin
          e.cyc = t0 + 1 + s * (pairs + P) + idx;
          e.a1  = base + k;
          e.a2  = base + k + h;
          e.tw  = k * (1 << (l - 1 - s));
          e.st  = s;
          rdq.push_back(e);
          e.cyc = e.cyc + P;
          wrq.push_back(e);
          idx++;
        end
      end
    end
    busy_from = t0 + 1;
    busy_to   = t0 + l * (pairs + P) + 1;
    doneq.push_back(busy_to);
  endtask

  task automatic purge_after(input int a);
    ev_t q[$];
    int  d[$];
    foreach (rdq[i]) if (rdq[i].cyc <= a) q.push_back(rdq[i]);
    rdq = q;
    q = {};
    foreach (wrq[i]) if (wrq[i].cyc <= a) q.push_back(wrq[i]);
    wrq = q;
    foreach (doneq[i]) if (doneq[i] <= a) d.push_back(doneq[i]);
    doneq = d;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      m_exp = (rdq.size() != 0) && (rdq[0].cyc == cyc);
      chk("rd_valid", int'(bus.o_rd_valid), int'(m_exp));
      if (m_exp) begin
        m_ev = rdq.pop_front();
        chk("rd_a1", int'(bus.o_raddress1), m_ev.a1);
        chk("rd_a2", int'(bus.o_raddress2), m_ev.a2);
        chk("rd_twiddle", int'(bus.o_twiddle), m_ev.tw);
        chk("rd_stage", int'(bus.o_stage), m_ev.st);
        hold_a1 = m_ev.a1;
        hold_a2 = m_ev.a2;
        hold_tw = m_ev.tw;
      end else if (!bus.o_rd_valid) begin
        chk("hold_a1", int'(bus.o_raddress1), hold_a1);
        chk("hold_a2", int'(bus.o_raddress2), hold_a2);
        chk("hold_twiddle", int'(bus.o_twiddle), hold_tw);
      end
      m_exp = (wrq.size() != 0) && (wrq[0].cyc == cyc);
      chk("wr_en", int'(bus.o_wr_en), int'(m_exp));
      if (m_exp) begin
        m_ev = wrq.pop_front();
        chk("wr_a1", int'(bus.o_waddress1), m_ev.a1);
        chk("wr_a2", int'(bus.o_waddress2), m_ev.a2);
      end
      m_exp = (doneq.size() != 0) && (doneq[0] == cyc);
      chk("done", int'(bus.o_done), int'(m_exp));
      if (m_exp) void'(doneq.pop_front());
      m_exp = (errq.size() != 0) && (errq[0] == cyc);
      chk("err", int'(bus.o_err), int'(m_exp));
      if (m_exp) void'(errq.pop_front());
      chk("busy", int'(bus.o_busy), int'(cyc >= busy_from && cyc <= busy_to));
    end
  end

  // All driver tasks are entered just after a falling edge.
  task automatic start_run(input int l);
    bus.i_start = 1'b1;
    bus.i_log2n = 4'(l);
    if (l >= 1 && l <= ML) push_run(l, cyc);
    else errq.push_back(cyc + 1);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic poke_start(input int l);
    bus.i_start = 1'b1;
    bus.i_log2n = 4'(l);
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic abort_now();
    bus.i_abort = 1'b1;
    purge_after(cyc);
    if (busy_to > cyc) busy_to = cyc;
    @(negedge clk);
    bus.i_abort = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.o_busy), 0);
    chk({tag, "_done"}, int'(bus.o_done), 0);
    chk({tag, "_err"}, int'(bus.o_err), 0);
    chk({tag, "_stage"}, int'(bus.o_stage), 0);
    chk({tag, "_rd_valid"}, int'(bus.o_rd_valid), 0);
    chk({tag, "_raddr"}, int'({bus.o_raddress1, bus.o_raddress2}), 0);
    chk({tag, "_twiddle"}, int'(bus.o_twiddle), 0);
    chk({tag, "_wr_en"}, int'(bus.o_wr_en), 0);
    chk({tag, "_waddr"}, int'({bus.o_waddress1, bus.o_waddress2}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, total, off, l;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_log2n = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // L=3 full run: 12 reads, 12 writes, done at cycle 25
    start_run(3);
    wait_until(busy_to + P + 2);

    // L=1 then restart the cycle after done
    start_run(1);
    t0 = busy_to;
    wait_until(t0 + 1);
    start_run(1);
    wait_until(busy_to + P + 2);

    // Illegal L values
    start_run(0);
    wait_until(cyc + 2);
    start_run(ML + 1);
    wait_until(cyc + 2);
    start_run(15);
    wait_until(cyc + 3);

    // Illegal start together with abort: no err
    bus.i_start = 1'b1;
    bus.i_log2n = '0;
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    wait_until(cyc + 3);

    // Abort in stage 1 ISSUE with two writes in flight
    start_run(3);
    t0 = cyc - 1;
    wait_until(t0 + 10);
    abort_now();
    wait_until(cyc + P + 4);

    // Starts while busy are ignored
    start_run(3);
    t0 = cyc - 1;
    wait_until(t0 + 5);
    poke_start(2);
    wait_until(t0 + 14);
    poke_start(0);
    wait_until(busy_to + P + 2);

    // Async reset in the middle of stage 0 DRAIN
    start_run(3);
    t0 = cyc - 1;
    wait_until(t0 + 6);
    mon_en = 1'b0;
    #2 rstn = 1'b0;
    #1 check_zero("midreset");
    rdq = {};
    wrq = {};
    doneq = {};
    errq = {};
    busy_from = 1;
    busy_to = 0;
    hold_a1 = 0;
    hold_a2 = 0;
    hold_tw = 0;
    @(negedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Largest transform
    start_run(ML);
    wait_until(busy_to + P + 2);

    // Randomised runs with random aborts and ignored starts
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        start_run(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(ML + 1, 15)));
        wait_until(cyc + 3);
      end else begin
        l = int'($urandom_range(1, 5));
        start_run(l);
        t0 = cyc - 1;
        total = busy_to - t0;
        off = int'($urandom_range(1, total));
        case ($urandom_range(0, 2))
          0: begin wait_until(t0 + off); abort_now(); end
          1: begin wait_until(t0 + off); poke_start(int'($urandom_range(0, 15))); end
          default: ;
        endcase
        wait_until(((busy_to > cyc) ? busy_to : cyc) + P + 2);
      end
    end

    chk("rd_left", rdq.size(), 0);
    chk("wr_left", wrq.size(), 0);
    chk("done_left", doneq.size(), 0);
    chk("err_left", errq.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
